// File: rtl/issue_pkg.sv
// Shared issue-queue types: instruction field layout, queue entry struct, decode helper.
// Latency: none (types and a pure function only).
// Backpressure: none.
package issue_pkg;

  localparam int INSTR_W   = 32;
  localparam int OP_W      = 4;
  localparam int FLD_REG_W = 4;
  localparam int FLD_BID_W = 3;
  localparam int IME_W     = 5;

  localparam int OP_LSB    = 28;
  localparam int DES_LSB   = 24;
  localparam int S1_LSB    = 20;
  localparam int S2_LSB    = 16;
  localparam int BID_LSB   = 13;
  localparam int IME_LSB   = 8;

  typedef struct packed {
    logic                 vld;
    logic [OP_W-1:0]      op;
    logic [FLD_REG_W-1:0] des;
    logic [FLD_REG_W-1:0] s1;
    logic [FLD_REG_W-1:0] s2;
    logic                 rdy1;
    logic                 rdy2;
    logic [FLD_BID_W-1:0] bid;
    logic [IME_W-1:0]     ime;
  } entry_t;

  // Unpack a dispatch word into a valid entry; readiness is filled in by the caller.
  function automatic entry_t decode(input logic [INSTR_W-1:0] w);
    entry_t e;
    logic   unused_lo;
    unused_lo = ^w[IME_LSB-1:0];
    e       = '0;
    e.vld   = 1'b1;
    e.op    = w[OP_LSB  +: OP_W];
    e.des   = w[DES_LSB +: FLD_REG_W];
    e.s1    = w[S1_LSB  +: FLD_REG_W];
    e.s2    = w[S2_LSB  +: FLD_REG_W];
    e.bid   = w[BID_LSB +: FLD_BID_W];
    e.ime   = w[IME_LSB +: IME_W];
    return e;
  endfunction

endpackage

// File: rtl/iq_select.sv
// Lowest-index-first picker: up to ISSUE_W one-hot grants from a DEPTH-bit request vector.
// Latency: purely combinational.
// Backpressure: none; requests beyond ISSUE_W simply stay ungranted this cycle.
module iq_select #(
  parameter int DEPTH   = 8,
  parameter int ISSUE_W = 4
) (
  input  logic [DEPTH-1:0]              req,
  output logic [ISSUE_W-1:0][DEPTH-1:0] grant
);

  logic [DEPTH-1:0] remain;

  // Each lane takes the lowest remaining request bit and removes it for later lanes.
  always_comb begin
    remain = req;
    grant  = '0;
    for (int l = 0; l < ISSUE_W; l++) begin
      grant[l] = remain & (~remain + DEPTH'(1));
      remain   = remain & ~grant[l];
    end
  end

endmodule

// File: rtl/issue_queue_param.sv
// Issue queue: dispatch into free slots, scoreboard wakeup, lowest-index select, branch-tag flush. Macro IQ_PERF_CNT_EN adds perf counters.
// Latency: entry written at edge k is eligible in cycle k+1 and appears on iq_out_* after edge k+1.
// Backpressure: registered iq_full drops every dispatch lane that cycle; the producer must hold.
module issue_queue_param
  import issue_pkg::*;
#(
  parameter  int DEPTH      = 8,
  parameter  int DISPATCH_W = 2,
  parameter  int ISSUE_W    = 4,
  parameter  int WB_W       = 4,
  parameter  int NUM_REGS   = 16,
  parameter  int BID_W      = 3,
  localparam int REG_W      = $clog2(NUM_REGS),
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DISPATCH_W*INSTR_W-1:0] new_instr_in,
  input  logic [DISPATCH_W-1:0]         ins_new_vld,
  input  logic                          flush_en,
  input  logic [BID_W-1:0]              flush_id,
  input  logic [NUM_REGS-1:0]           flush_reg,
  input  logic [WB_W-1:0]               ins_back_vld,
  input  logic [WB_W*REG_W-1:0]         ins_back_des,
  output logic                          iq_full,
  output logic                          iq_empty,
  output logic [CNT_W-1:0]              iq_count,
  output logic [ISSUE_W-1:0]            iq_out_vld,
  output logic [ISSUE_W*OP_W-1:0]       iq_out_op,
  output logic [ISSUE_W*REG_W-1:0]      iq_out_des,
  output logic [ISSUE_W*REG_W-1:0]      iq_out_s1,
  output logic [ISSUE_W*REG_W-1:0]      iq_out_s2,
  output logic [ISSUE_W*BID_W-1:0]      iq_out_bid,
`ifdef IQ_PERF_CNT_EN
  output logic [ISSUE_W*IME_W-1:0]      iq_out_ime,
  output logic [31:0]                   perf_issue_cnt,
  output logic [31:0]                   perf_stall_cnt
`else
  output logic [ISSUE_W*IME_W-1:0]      iq_out_ime
`endif
);

  entry_t [DEPTH-1:0]              ent_q, ent_d;
  entry_t [ISSUE_W-1:0]            sel_ent;
  entry_t                          lane_ent;
  logic   [NUM_REGS-1:0]           busy_q, busy_d, busy_eff, wb_mask, grp_des;
  logic   [DEPTH-1:0]              kill, req, issued, taken;
  logic   [ISSUE_W-1:0][DEPTH-1:0] grant;
  logic                            found;
  logic   [CNT_W-1:0]              cnt_d;

  // Collapse all writeback ports into one register mask.
  always_comb begin
    wb_mask = '0;
    for (int w = 0; w < WB_W; w++) begin
      if (ins_back_vld[w]) wb_mask[ins_back_des[w*REG_W +: REG_W]] = 1'b1;
    end
  end

  // Flush victims never compete in this cycle's select.
  always_comb begin
    kill = '0;
    req  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = flush_en && ent_q[i].vld && (ent_q[i].bid == FLD_BID_W'(flush_id));
      req[i]  = ent_q[i].vld && ent_q[i].rdy1 && ent_q[i].rdy2 && !kill[i];
    end
  end

  iq_select #(
    .DEPTH   (DEPTH),
    .ISSUE_W (ISSUE_W)
  ) u_select (
    .req   (req),
    .grant (grant)
  );

  // Route each lane's granted entry; ungranted lanes see an all-zero entry.
  always_comb begin
    issued  = '0;
    sel_ent = '0;
    for (int l = 0; l < ISSUE_W; l++) begin
      issued = issued | grant[l];
      for (int i = 0; i < DEPTH; i++) begin
        if (grant[l][i]) sel_ent[l] = sel_ent[l] | ent_q[i];
      end
    end
  end

  // Next queue contents and scoreboard: free/kill, wakeup, then dispatch (newest wins busy).
  always_comb begin
    busy_eff = busy_q & ~(flush_reg & {NUM_REGS{flush_en}});
    busy_d   = busy_eff & ~wb_mask;
    ent_d    = ent_q;
    taken    = '0;
    grp_des  = '0;
    lane_ent = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill[i] || issued[i]) begin
        ent_d[i] = '0;
      end else if (ent_q[i].vld) begin
        if (wb_mask[ent_q[i].s1]) ent_d[i].rdy1 = 1'b1;
        if (wb_mask[ent_q[i].s2]) ent_d[i].rdy2 = 1'b1;
      end
    end
    // Slots are taken from those empty at the start of the cycle, lowest index first.
    for (int l = 0; l < DISPATCH_W; l++) begin
      lane_ent = decode(new_instr_in[l*INSTR_W +: INSTR_W]);
      found    = 1'b0;
      if (!iq_full && ins_new_vld[l] &&
          !(flush_en && (lane_ent.bid == FLD_BID_W'(flush_id)))) begin
        lane_ent.rdy1 = (!busy_eff[lane_ent.s1] || wb_mask[lane_ent.s1]) && !grp_des[lane_ent.s1];
        lane_ent.rdy2 = (!busy_eff[lane_ent.s2] || wb_mask[lane_ent.s2]) && !grp_des[lane_ent.s2];
        for (int i = 0; i < DEPTH; i++) begin
          if (!found && !ent_q[i].vld && !taken[i]) begin
            ent_d[i] = lane_ent;
            taken[i] = 1'b1;
            found    = 1'b1;
          end
        end
        if (found) begin
          grp_des[lane_ent.des] = 1'b1;
          busy_d[lane_ent.des]  = 1'b1;
        end
      end
    end
  end

  // Population count of the post-edge queue.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CNT_W'(ent_d[i].vld);
  end

  // Queue state, scoreboard and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q    <= '0;
      busy_q   <= '0;
      iq_count <= '0;
      iq_full  <= 1'b0;
      iq_empty <= 1'b1;
    end else begin
      ent_q    <= ent_d;
      busy_q   <= busy_d;
      iq_count <= cnt_d;
      iq_full  <= (int'(cnt_d) > DEPTH - DISPATCH_W);
      iq_empty <= (cnt_d == '0);
    end
  end

  // Issue lanes; a granted entry is by construction valid and ready on both sources.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iq_out_vld <= '0;
      iq_out_op  <= '0;
      iq_out_des <= '0;
      iq_out_s1  <= '0;
      iq_out_s2  <= '0;
      iq_out_bid <= '0;
      iq_out_ime <= '0;
    end else begin
      for (int l = 0; l < ISSUE_W; l++) begin
        iq_out_vld[l]                  <= sel_ent[l].vld & sel_ent[l].rdy1 & sel_ent[l].rdy2;
        iq_out_op [l*OP_W  +: OP_W]    <= sel_ent[l].op;
        iq_out_des[l*REG_W +: REG_W]   <= REG_W'(sel_ent[l].des);
        iq_out_s1 [l*REG_W +: REG_W]   <= REG_W'(sel_ent[l].s1);
        iq_out_s2 [l*REG_W +: REG_W]   <= REG_W'(sel_ent[l].s2);
        iq_out_bid[l*BID_W +: BID_W]   <= BID_W'(sel_ent[l].bid);
        iq_out_ime[l*IME_W +: IME_W]   <= sel_ent[l].ime;
      end
    end
  end

`ifdef IQ_PERF_CNT_EN
  logic [32:0] issue_sum;

  // Issue total with headroom bit for saturation.
  always_comb begin
    issue_sum = {1'b0, perf_issue_cnt};
    for (int i = 0; i < DEPTH; i++) issue_sum = issue_sum + 33'(issued[i]);
  end

  // Saturating issue and stall counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_issue_cnt <= issue_sum[32] ? '1 : issue_sum[31:0];
      if ((|ins_new_vld) && iq_full && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue_param.sv
// Self-checking bench for issue_queue_param: directed scenarios then random traffic vs a queue model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: model honours registered iq_full by dropping dispatch while full.
module tb_issue_queue_param;

  localparam int DEPTH = 8;
  localparam int DW    = 2;
  localparam int IW    = 4;
  localparam int WW    = 4;
  localparam int NR    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] new_instr_in;
  logic [1:0]  ins_new_vld;
  logic        flush_en;
  logic [2:0]  flush_id;
  logic [15:0] flush_reg;
  logic [3:0]  ins_back_vld;
  logic [15:0] ins_back_des;
  logic        iq_full, iq_empty;
  logic [3:0]  iq_count;
  logic [3:0]  iq_out_vld;
  logic [15:0] iq_out_op, iq_out_des, iq_out_s1, iq_out_s2;
  logic [11:0] iq_out_bid;
  logic [19:0] iq_out_ime;
`ifdef IQ_PERF_CNT_EN
  logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  issue_queue_param dut (
    .clk          (clk),
    .rst          (rst),
    .new_instr_in (new_instr_in),
    .ins_new_vld  (ins_new_vld),
    .flush_en     (flush_en),
    .flush_id     (flush_id),
    .flush_reg    (flush_reg),
    .ins_back_vld (ins_back_vld),
    .ins_back_des (ins_back_des),
    .iq_full      (iq_full),
    .iq_empty     (iq_empty),
    .iq_count     (iq_count),
    .iq_out_vld   (iq_out_vld),
    .iq_out_op    (iq_out_op),
    .iq_out_des   (iq_out_des),
    .iq_out_s1    (iq_out_s1),
    .iq_out_s2    (iq_out_s2),
    .iq_out_bid   (iq_out_bid),
`ifdef IQ_PERF_CNT_EN
    .iq_out_ime     (iq_out_ime),
    .perf_issue_cnt (perf_issue_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`else
    .iq_out_ime   (iq_out_ime)
`endif
  );

  // Reference model: a slot array of decoded instructions plus a busy bit per register.
  typedef struct {
    bit v;
    int op, des, s1, s2, bid, ime;
    bit r1, r2;
  } me_t;

  me_t mq[DEPTH];
  bit  mbusy[NR];
  bit  mfull;
  int  iss_total, stall_total;

  logic [3:0]  e_vld;
  logic [15:0] e_op, e_des, e_s1, e_s2;
  logic [11:0] e_bid;
  logic [19:0] e_ime;
  int          e_count;
  bit          e_full, e_empty;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mq[i].v = 0; mq[i].op = 0; mq[i].des = 0; mq[i].s1 = 0; mq[i].s2 = 0;
      mq[i].bid = 0; mq[i].ime = 0; mq[i].r1 = 0; mq[i].r2 = 0;
    end
    for (int r = 0; r < NR; r++) mbusy[r] = 0;
    mfull = 0; iss_total = 0; stall_total = 0;
    e_vld = '0; e_op = '0; e_des = '0; e_s1 = '0; e_s2 = '0; e_bid = '0; e_ime = '0;
    e_count = 0; e_full = 0; e_empty = 1;
  endtask

  // Apply one clock's worth of the queue rules to the model using the currently driven inputs.
  task automatic model_cycle();
    bit          wbm[NR];
    bit          busy_f[NR];
    bit          grp[NR];
    bit          used[DEPTH];
    me_t         old[DEPTH];
    me_t         ne;
    logic [31:0] w;
    int          n, slot, cnt;
    for (int r = 0; r < NR; r++) begin wbm[r] = 0; grp[r] = 0; end
    for (int i = 0; i < DEPTH; i++) begin used[i] = 0; old[i] = mq[i]; end
    for (int p = 0; p < WW; p++) if (ins_back_vld[p]) wbm[ins_back_des[p*4 +: 4]] = 1;
    e_vld = '0; e_op = '0; e_des = '0; e_s1 = '0; e_s2 = '0; e_bid = '0; e_ime = '0;
    n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (old[i].v && old[i].r1 && old[i].r2 && !(flush_en && old[i].bid == flush_id) && n < IW) begin
        e_vld[n]         = 1'b1;
        e_op [n*4 +: 4]  = 4'(old[i].op);
        e_des[n*4 +: 4]  = 4'(old[i].des);
        e_s1 [n*4 +: 4]  = 4'(old[i].s1);
        e_s2 [n*4 +: 4]  = 4'(old[i].s2);
        e_bid[n*3 +: 3]  = 3'(old[i].bid);
        e_ime[n*5 +: 5]  = 5'(old[i].ime);
        mq[i].v = 0;
        n++;
      end
    end
    iss_total += n;
    for (int i = 0; i < DEPTH; i++) begin
      if (mq[i].v) begin
        if (flush_en && mq[i].bid == flush_id) mq[i].v = 0;
        else begin
          if (wbm[mq[i].s1]) mq[i].r1 = 1;
          if (wbm[mq[i].s2]) mq[i].r2 = 1;
        end
      end
    end
    for (int r = 0; r < NR; r++) begin
      busy_f[r] = mbusy[r] && !(flush_en && flush_reg[r]);
      mbusy[r]  = busy_f[r] && !wbm[r];
    end
    if (ins_new_vld != 0 && mfull) stall_total++;
    if (!mfull) begin
      for (int l = 0; l < DW; l++) begin
        if (!ins_new_vld[l]) continue;
        w = new_instr_in[l*32 +: 32];
        ne.v = 1; ne.op = w[31:28]; ne.des = w[27:24]; ne.s1 = w[23:20];
        ne.s2 = w[19:16]; ne.bid = w[15:13]; ne.ime = w[12:8];
        if (flush_en && ne.bid == flush_id) continue;
        ne.r1 = (!busy_f[ne.s1] || wbm[ne.s1]) && !grp[ne.s1];
        ne.r2 = (!busy_f[ne.s2] || wbm[ne.s2]) && !grp[ne.s2];
        slot = -1;
        for (int i = 0; i < DEPTH; i++) if (slot < 0 && !old[i].v && !used[i]) slot = i;
        if (slot >= 0) begin
          mq[slot] = ne; used[slot] = 1; grp[ne.des] = 1; mbusy[ne.des] = 1;
        end
      end
    end
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) cnt += int'(mq[i].v);
    e_count = cnt;
    e_full  = (DEPTH - cnt) < DW;
    e_empty = (cnt == 0);
    mfull   = e_full;
  endtask

  task automatic compare_all();
    check("out_vld", iq_out_vld, e_vld);
    check("out_op",  iq_out_op,  e_op);
    check("out_des", iq_out_des, e_des);
    check("out_s1",  iq_out_s1,  e_s1);
    check("out_s2",  iq_out_s2,  e_s2);
    check("out_bid", iq_out_bid, e_bid);
    check("out_ime", iq_out_ime, e_ime);
    check("count",   iq_count,   e_count);
    check("full",    iq_full,    e_full);
    check("empty",   iq_empty,   e_empty);
`ifdef IQ_PERF_CNT_EN
    check("perf_issue", perf_issue_cnt, iss_total);
    check("perf_stall", perf_stall_cnt, stall_total);
`endif
  endtask

  task automatic idle_inputs();
    ins_new_vld = '0; ins_back_vld = '0; flush_en = 1'b0; flush_id = '0; flush_reg = '0;
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    compare_all();
    idle_inputs();
  endtask

  function automatic logic [31:0] mk(input int op, input int des, input int s1, input int s2,
                                     input int bid, input int ime);
    logic [31:0] w;
    w        = 32'($urandom);
    w[31:28] = op[3:0];
    w[27:24] = des[3:0];
    w[23:20] = s1[3:0];
    w[19:16] = s2[3:0];
    w[15:13] = bid[2:0];
    w[12:8]  = ime[4:0];
    return w;
  endfunction

  task automatic disp(input int l, input logic [31:0] w);
    new_instr_in[l*32 +: 32] = w;
    ins_new_vld[l]           = 1'b1;
  endtask

  task automatic wbk(input int p, input int r);
    ins_back_vld[p]         = 1'b1;
    ins_back_des[p*4 +: 4]  = 4'(r);
  endtask

  // Wake every register, then idle long enough for the queue to empty.
  task automatic drain();
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < WW; p++) wbk(p, 4*k + p);
      step();
    end
    repeat (4) step();
  endtask

  initial begin
    rst          = 1'b0;
    new_instr_in = '0;
    ins_back_des = '0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;

    // Two independent instructions issue together, then the queue empties.
    disp(0, mk(1, 3, 1, 2, 0, 5));
    disp(1, mk(2, 4, 1, 2, 0, 7));
    step();
    step();
    check("t1_vld", iq_out_vld, 4'b0011);
    check("t1_des", iq_out_des[7:0], 8'h43);
    step();
    check("t1_empty", iq_empty, 1'b1);

    // Same-group dependency holds B until its producer's writeback.
    disp(0, mk(3, 5, 1, 2, 1, 0));
    disp(1, mk(4, 6, 5, 1, 1, 0));
    step();
    step();
    check("t2_a_vld", iq_out_vld, 4'b0001);
    check("t2_a_des", iq_out_des[3:0], 4'd5);
    step();
    check("t2_hold_vld", iq_out_vld, 4'b0000);
    check("t2_hold_cnt", iq_count, 4'd1);
    wbk(0, 5);
    step();
    step();
    check("t2_b_vld", iq_out_vld, 4'b0001);
    check("t2_b_s1", iq_out_s1[3:0], 4'd5);
    step();
    drain();

    // Fill with blocked entries, then confirm a full queue drops dispatch.
    disp(0, mk(5, 10, 0, 1, 0, 0));
    step();
    for (int g = 0; g < 4; g++) begin
      disp(0, mk(6, 11, 10, 0, 0, 1));
      disp(1, mk(6, 12, 10, 0, 0, 2));
      step();
    end
    check("t3_full", iq_full, 1'b1);
    check("t3_cnt", iq_count, 4'd8);
    disp(0, mk(6, 13, 0, 0, 0, 3));
    disp(1, mk(6, 14, 0, 0, 0, 4));
    step();
    check("t3_drop_cnt", iq_count, 4'd8);
    drain();

    // Six ready at once: four issue, then two.
    disp(0, mk(7, 10, 0, 1, 0, 0));
    step();
    for (int g = 0; g < 3; g++) begin
      disp(0, mk(8, 13, 10, 0, 1, g));
      disp(1, mk(9, 14, 10, 0, 1, g + 8));
      step();
    end
    check("t5_cnt", iq_count, 4'd6);
    wbk(0, 10);
    step();
    step();
    check("t5_first_vld", iq_out_vld, 4'b1111);
    step();
    check("t5_second_vld", iq_out_vld, 4'b0011);
    drain();

    // Flush bid 2 (queued and incoming) and clear busy[5].
    disp(0, mk(1, 12, 0, 0, 0, 0));
    step();
    disp(0, mk(2, 5, 12, 0, 2, 1));
    disp(1, mk(3, 6, 12, 0, 3, 2));
    step();
    disp(0, mk(4, 7, 12, 0, 2, 3));
    disp(1, mk(5, 8, 12, 0, 3, 4));
    step();
    check("t4_pre_cnt", iq_count, 4'd4);
    flush_en  = 1'b1;
    flush_id  = 3'd2;
    flush_reg = 16'h0020;
    disp(0, mk(6, 9, 12, 0, 2, 5));
    disp(1, mk(7, 11, 12, 0, 3, 6));
    step();
    check("t4_post_cnt", iq_count, 4'd3);
    disp(0, mk(8, 1, 5, 0, 4, 0));
    step();
    step();
    check("t4_busy5_vld", iq_out_vld, 4'b0001);
    check("t4_busy5_s1", iq_out_s1[3:0], 4'd5);
    drain();

    // Writeback in the dispatch cycle makes the source ready immediately.
    disp(0, mk(9, 7, 0, 0, 0, 0));
    step();
    step();
    disp(0, mk(11, 2, 7, 0, 0, 0));
    wbk(0, 7);
    step();
    step();
    check("t6_vld", iq_out_vld, 4'b0001);
    check("t6_op", iq_out_op[3:0], 4'd11);
    drain();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      new_instr_in = {$urandom, $urandom};
      ins_new_vld  = 2'($urandom);
      for (int p = 0; p < WW; p++) if ($urandom_range(0, 2) == 0) wbk(p, $urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) begin
        flush_en    = 1'b1;
        flush_id    = 3'($urandom);
        flush_reg   = 16'($urandom);
        ins_new_vld = '0;
      end
      step();
    end

    // Asynchronous reset mid-cycle clears everything without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    disp(0, mk(2, 3, 4, 5, 6, 7));
    step();
    step();
    check("post_rst_vld", iq_out_vld, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_queue_param.md
Name: issue_queue_param

Overview:
Parametrised successor to the fixed 2-in/4-out issue stage. It accepts up to DISPATCH_W decoded instructions per cycle into a DEPTH-entry queue and tracks source readiness with an internal register scoreboard. Writeback broadcasts wake up waiting entries, and up to ISSUE_W ready entries issue per cycle. Branch-tagged entries are squashed on flush. It sits between decode/rename and the execution lanes.

Parameters:
DEPTH, 8, queue entries (power of two, ≥ DISPATCH_W)
DISPATCH_W, 2, instructions accepted per cycle
ISSUE_W, 4, issue lanes
WB_W, 4, writeback broadcast ports
NUM_REGS, 16, architectural registers; REG_W = $clog2(NUM_REGS)
BID_W, 3, branch tag width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
new_instr_in  in  DISPATCH_W*32  packed instructions, lane i at [32i+31:32i]
ins_new_vld  in  DISPATCH_W  per-lane dispatch valid
flush_en  in  1  branch mispredict flush
flush_id  in  BID_W  tag to squash
flush_reg  in  NUM_REGS  scoreboard busy bits to clear on flush
ins_back_vld  in  WB_W  writeback valid
ins_back_des  in  WB_W*REG_W  writeback destinations
iq_full  out  1  free entries < DISPATCH_W
iq_empty  out  1  no valid entries
iq_count  out  $clog2(DEPTH)+1  valid entry count
iq_out_vld  out  ISSUE_W  issue valid per lane
iq_out_op  out  ISSUE_W*4  opcode
iq_out_des  out  ISSUE_W*REG_W  destination
iq_out_s1  out  ISSUE_W*REG_W  source 1
iq_out_s2  out  ISSUE_W*REG_W  source 2
iq_out_bid  out  ISSUE_W*BID_W  branch tag
iq_out_ime  out  ISSUE_W*5  immediate

Behaviour:
- Instruction format: op[31:28], des[27:24], s1[23:20], s2[19:16], bid[15:13], imm[12:8]; [7:0] ignored.
- Reset (rst=0, async): all entries invalid, scoreboard all not-busy, all iq_out_* = 0, iq_empty=1, iq_full=0, iq_count=0.
- Dispatch: when iq_full=0, each lane with ins_new_vld=1 is written into the lowest-index free slots, in lane order. When iq_full=1, all lanes are dropped; the producer must hold.
- Each written entry sets the scoreboard busy bit for its des.
- Source ready at dispatch = source not busy, OR source matches a same-cycle ins_back_des. A source matching an older lane's des in the same dispatch group is not ready.
- Wakeup: each valid ins_back lane clears busy[des] and sets rdy for every entry source that matches.
- If dispatch and writeback name the same des in one cycle, busy is set (dispatch is newer).
- Select: entries with both sources ready, lowest index first, up to ISSUE_W per cycle. An entry is eligible from the cycle after it is written.
- Issued entries are freed at the same edge.
- Outputs are registered: the entry is selected in cycle k and appears on iq_out_* after edge k. Lanes are filled from lane 0 upward; unused lanes show vld=0 with all fields 0.
- Flush: flush_en=1 invalidates every entry and every incoming lane with bid==flush_id. Those entries are excluded from that cycle's select. busy &= ~flush_reg.
- Writeback applies in the same cycle as a flush.
- iq_full, iq_empty and iq_count are registered and reflect post-edge state.

Optional Feature:
IQ_PERF_CNT_EN: adds output perf_issue_cnt[31:0] and output perf_stall_cnt[31:0].
- perf_issue_cnt: running total of issued instructions.
- perf_stall_cnt: cycles with any ins_new_vld while iq_full=1.
- Both counters saturate at all-ones and reset to 0.
- Without the macro, the ports and counters do not exist.

Decomposition:
- Package issue_pkg: INSTR_W=32 and field-position constants; entry struct (vld, op, des, s1, s2, rdy1, rdy2, bid, ime); decode function from 32-bit word to entry.
- Sub-module iq_select: combinational lowest-index pick of up to ISSUE_W from a DEPTH-bit request vector, producing one-hot grants per lane.

Test Plan:
- Reset, then dispatch two independent instrs (s1=1, s2=2, regs idle) → both appear on iq_out lanes 0–1 two cycles later; iq_empty returns to 1.
- Dispatch instr A (des=5) with instr B (s1=5) in the same group → A issues; B holds. Writeback des=5 → B issues two cycles later.
- Fill 8 entries with blocked sources → iq_full=1 and iq_count=8. A further dispatch is dropped and iq_count stays 8.
- Queue holds bid=2 and bid=3 entries; flush_en with flush_id=2 and flush_reg=16'h0020 → only bid=3 entries remain, and busy[5] is cleared.
- Six ready entries with ISSUE_W=4 → 4 issue in cycle k (slots 0–3) and 2 issue in cycle k+1.
- Dispatch with s1=7 in the same cycle as writeback des=7 → source is ready, and the entry issues without waiting.
